// File: rtl/modred_pkg.sv
`default_nettype none
// ============================================================================
// Module   : modred_pkg
// Purpose  : Shared defaults, mode encodings and Barrett constant helper for
//            the modular reduction pipeline.
// Revision : 1.0 - initial pipelined Barrett release
// ============================================================================
package modred_pkg;

    localparam int unsigned MODRED_Q_WIDTH    = 23;
    localparam int unsigned MODRED_Q          = 8380417;
    localparam int unsigned MODRED_DATA_WIDTH = 2 * MODRED_Q_WIDTH;
    localparam int unsigned MODRED_TAG_WIDTH  = 4;

    localparam logic MODE_CANON  = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // floor(2^(2k) / q); valid for k up to 31
    function automatic logic [63:0] barrett_mu(input logic [63:0] q, input int unsigned k);
        logic [63:0] num;
        num = 64'd1 << (2 * k);
        return num / q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/barrett_reduce_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : barrett_reduce_pipe_if
// Purpose  : Operand-in / result-out valid-ready bundle for the reducer.
// Revision : 1.0 - initial pipelined Barrett release
// ============================================================================
interface barrett_reduce_pipe_if
    import modred_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MODRED_DATA_WIDTH,
    parameter int unsigned Q_WIDTH    = MODRED_Q_WIDTH,
    parameter int unsigned TAG_WIDTH  = MODRED_TAG_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_mode;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [Q_WIDTH:0]      out_data;
    logic [TAG_WIDTH-1:0]  out_tag;

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface
`default_nettype wire

// File: rtl/modred_final_sub.sv
`default_nettype none
// ============================================================================
// Module   : modred_final_sub
// Purpose  : Final Barrett correction (r in [0,3Q) -> [0,Q)) and optional
//            centering into the signed symmetric range.
// Revision : 1.0 - initial pipelined Barrett release
// ============================================================================
module modred_final_sub
    import modred_pkg::*;
#(
    parameter int unsigned Q_WIDTH = MODRED_Q_WIDTH,
    parameter int unsigned Q       = MODRED_Q
) (
    input  wire logic [Q_WIDTH+1:0] i_r,
    input  wire logic               i_mode,
    output logic      [Q_WIDTH:0]   o_data
);

    localparam int unsigned       c_K         = Q_WIDTH;
    localparam logic [63:0]       c_Q_FULL    = 64'(Q);
    localparam logic [63:0]       c_2Q_FULL   = c_Q_FULL << 1;
    localparam logic [63:0]       c_HALF_FULL = (c_Q_FULL - 64'd1) >> 1;
    localparam logic [c_K+2:0]    c_Q1        = c_Q_FULL[c_K+2:0];
    localparam logic [c_K+2:0]    c_Q2        = c_2Q_FULL[c_K+2:0];
    localparam logic [c_K:0]      c_QC        = c_Q_FULL[c_K:0];
    localparam logic [c_K-1:0]    c_HALF      = c_HALF_FULL[c_K-1:0];

    logic [c_K+2:0] w_rx;
    logic [c_K+2:0] w_d1;
    logic [c_K+2:0] w_d2;
    logic [c_K-1:0] w_c;
    logic           w_unused;

    // one extra bit so the MSB of each difference acts as its sign
    assign w_rx = {1'b0, i_r};
    assign w_d1 = w_rx - c_Q1;
    assign w_d2 = w_rx - c_Q2;
    assign w_unused = ^{w_d1[c_K+1:c_K], w_d2[c_K+1:c_K]};

    always_comb begin
        w_c = i_r[c_K-1:0];
        if (!w_d2[c_K+2]) begin
            w_c = w_d2[c_K-1:0];
        end else if (!w_d1[c_K+2]) begin
            w_c = w_d1[c_K-1:0];
        end
    end

    always_comb begin
        o_data = {1'b0, w_c};
        if ((i_mode == MODE_CENTER) && (w_c > c_HALF)) begin
            o_data = {1'b0, w_c} - c_QC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/barrett_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module   : barrett_reduce_pipe
// Purpose  : Fully pipelined Barrett reducer, x mod Q with 4-cycle latency,
//            one operand per cycle, global-stall valid/ready flow control.
// Revision : 1.0 - initial pipelined Barrett release
// ============================================================================
module barrett_reduce_pipe
    import modred_pkg::*;
#(
    parameter int unsigned Q_WIDTH    = MODRED_Q_WIDTH,
    parameter int unsigned Q          = MODRED_Q,
    parameter int unsigned DATA_WIDTH = MODRED_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = MODRED_TAG_WIDTH
) (
    input wire logic             clk,
    input wire logic             rst,
    barrett_reduce_pipe_if.slave bus
);

    localparam int unsigned    c_K       = Q_WIDTH;
    localparam logic [63:0]    c_MU_FULL = barrett_mu(64'(Q), Q_WIDTH);
    localparam logic [63:0]    c_Q_FULL  = 64'(Q);
    localparam logic [c_K:0]   c_MU      = c_MU_FULL[c_K:0];
    localparam logic [c_K+1:0] c_Q_LO    = c_Q_FULL[c_K+1:0];

    logic                  w_en;
    logic [c_K:0]          w_q1;
    logic [2*c_K+1:0]      w_p;
    logic [c_K:0]          w_qh;
    logic [c_K+1:0]        w_m;
    logic [c_K+1:0]        w_r;
    logic [c_K:0]          w_final;
    logic                  w_unused;

    logic                  r_v0, r_v1, r_v2, r_v3;
    logic                  r_mode0, r_mode1, r_mode2, r_mode3;
    logic [TAG_WIDTH-1:0]  r_tag0, r_tag1, r_tag2, r_tag3;
    logic [DATA_WIDTH-1:0] r_x0;
    logic [c_K+1:0]        r_x1, r_x2;
    logic [2*c_K+1:0]      r_p1;
    logic [c_K+1:0]        r_m2;
    logic [c_K+1:0]        r_r3;
    logic                  r_out_valid;
    logic [c_K:0]          r_out_data;
    logic [TAG_WIDTH-1:0]  r_out_tag;

    assign w_en = !r_out_valid || bus.out_ready;

    // only the top K+1 bits of p and the low K+2 bits of x matter downstream
    assign w_q1     = r_x0[DATA_WIDTH-1:c_K-1];
    assign w_p      = {{(c_K+1){1'b0}}, w_q1} * {{(c_K+1){1'b0}}, c_MU};
    assign w_qh     = r_p1[2*c_K+1:c_K+1];
    assign w_m      = {1'b0, w_qh} * c_Q_LO;
    assign w_r      = r_x2 - r_m2;
    assign w_unused = ^{1'b0, r_p1[c_K:0]};

    modred_final_sub #(
        .Q_WIDTH (Q_WIDTH),
        .Q       (Q)
    ) u_final (
        .i_r    (r_r3),
        .i_mode (r_mode3),
        .o_data (w_final)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_mode0     <= 1'b0;
            r_mode1     <= 1'b0;
            r_mode2     <= 1'b0;
            r_mode3     <= 1'b0;
            r_tag0      <= '0;
            r_tag1      <= '0;
            r_tag2      <= '0;
            r_tag3      <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_p1        <= '0;
            r_m2        <= '0;
            r_r3        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else if (w_en) begin
            r_v0        <= bus.in_valid;
            r_x0        <= bus.in_data;
            r_mode0     <= bus.in_mode;
            r_tag0      <= bus.in_tag;

            r_v1        <= r_v0;
            r_p1        <= w_p;
            r_x1        <= r_x0[c_K+1:0];
            r_mode1     <= r_mode0;
            r_tag1      <= r_tag0;

            r_v2        <= r_v1;
            r_m2        <= w_m;
            r_x2        <= r_x1;
            r_mode2     <= r_mode1;
            r_tag2      <= r_tag1;

            r_v3        <= r_v2;
            r_r3        <= w_r;
            r_mode3     <= r_mode2;
            r_tag3      <= r_tag2;

            r_out_valid <= r_v3;
            r_out_data  <= w_final;
            r_out_tag   <= r_tag3;
        end
    end

    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_barrett_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrett_reduce_pipe
// Purpose  : Directed and random checks of the Barrett reducer (Q=8380417)
//            plus a strided sweep of a Q=3329 instance.
// Revision : 1.0 - initial pipelined Barrett release
// ============================================================================
module tb_barrett_reduce_pipe;
    import modred_pkg::*;

    typedef struct {
        logic [45:0] x;
        logic        mode;
        logic [23:0] exp;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic [3:0]  t;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    barrett_reduce_pipe_if #(.DATA_WIDTH(46), .Q_WIDTH(23), .TAG_WIDTH(4)) mb ();
    barrett_reduce_pipe_if #(.DATA_WIDTH(24), .Q_WIDTH(12), .TAG_WIDTH(4)) sbus ();

    barrett_reduce_pipe #(
        .Q_WIDTH(23), .Q(8380417), .DATA_WIDTH(46), .TAG_WIDTH(4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mb)
    );

    barrett_reduce_pipe #(
        .Q_WIDTH(12), .Q(3329), .DATA_WIDTH(24), .TAG_WIDTH(4)
    ) u_dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    vec_t        vecs [9];
    exp_t        sq_main[$];
    logic [12:0] sq_small[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          idle_cnt = 0;
    int          sent = 0;
    int          rcvd = 0;
    logic [4:0]  mv = '0;
    bit          chk_lat = 1'b0;
    bit          track_idle = 1'b0;
    bit          seen_out = 1'b0;

    function automatic logic [23:0] ref_main(input logic [45:0] x, input logic m);
        logic [63:0] c;
        c = 64'(x) % 64'd8380417;
        if (m && (c > 64'd4190208)) c = c + 64'd16777216 - 64'd8380417;
        return c[23:0];
    endfunction

    function automatic logic [12:0] ref_small(input logic [23:0] x, input logic m);
        logic [63:0] c;
        c = 64'(x) % 64'd3329;
        if (m && (c > 64'd1664)) c = c + 64'd8192 - 64'd3329;
        return c[12:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // one clock of the main DUT, entered and left just after a falling edge
    task automatic main_cycle(input logic v, input logic [45:0] x, input logic m,
                              input logic [3:0] t, input logic [23:0] e, input logic ordy);
        logic acc;
        logic en;
        mb.in_valid  = v;
        mb.in_data   = x;
        mb.in_mode   = m;
        mb.in_tag    = t;
        mb.out_ready = ordy;
        #1;
        chk("out_valid", 64'(mb.out_valid), 64'(mv[4]));
        chk("in_ready", 64'(mb.in_ready), 64'(!mv[4] || ordy));
        if (track_idle && seen_out && !mb.out_valid && (sq_main.size() > 0)) idle_cnt++;
        if (mb.out_valid) begin
            seen_out = 1'b1;
            if (sq_main.size() == 0) begin
                chk("unexpected_output", 64'(mb.out_tag), 64'hDEAD);
            end else begin
                chk("out_data", 64'(mb.out_data), 64'(sq_main[0].d));
                chk("out_tag", 64'(mb.out_tag), 64'(sq_main[0].t));
                if (ordy) begin
                    if (chk_lat) chk("latency", 64'(cyc - sq_main[0].acc), 64'd4);
                    void'(sq_main.pop_front());
                    rcvd++;
                end
            end
        end
        en  = !mv[4] || ordy;
        acc = v && en;
        if (acc) begin
            sq_main.push_back('{e, t, cyc + 1});
            sent++;
        end
        @(posedge clk);
        if (en) mv = {mv[3:0], acc};
        cyc++;
        @(negedge clk);
    endtask

    task automatic small_cycle(input logic v, input logic [23:0] x, input logic m);
        sbus.in_valid  = v;
        sbus.in_data   = x;
        sbus.in_mode   = m;
        sbus.in_tag    = x[3:0];
        sbus.out_ready = 1'b1;
        #1;
        if (sbus.out_valid) begin
            if (sq_small.size() == 0) chk("small_unexpected", 64'(sbus.out_data), 64'hDEAD);
            else chk("small_data", 64'(sbus.out_data), 64'(sq_small.pop_front()));
        end
        if (v && sbus.in_ready) sq_small.push_back(ref_small(x, m));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst            = 1'b1;
        mb.in_valid    = 1'b0;
        mb.out_ready   = 1'b1;
        sbus.in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mv  = '0;
        sq_main.delete();
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) main_cycle(1'b0, 46'd0, 1'b0, 4'd0, 24'd0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;
        logic [45:0] x;
        logic        m;
        int          r0;

        vecs[0] = '{46'd0, MODE_CANON, 24'd0};
        vecs[1] = '{46'd8380417, MODE_CANON, 24'd0};
        vecs[2] = '{46'd8380416, MODE_CANON, 24'd8380416};
        vecs[3] = '{46'(64'd8380416 * 64'd8380416), MODE_CANON, 24'd1};
        vecs[4] = '{46'h3FFF_FFFF_FFFF, MODE_CANON, 24'd49144};
        vecs[5] = '{46'd8380416, MODE_CENTER, 24'hFFFFFF};
        vecs[6] = '{46'd4190208, MODE_CENTER, 24'd4190208};
        vecs[7] = '{46'd4190209, MODE_CENTER, 24'hC01000};
        vecs[8] = '{46'd25141251, MODE_CENTER, 24'd0};

        rst            = 1'b1;
        mb.in_valid    = 1'b0;
        mb.in_data     = '0;
        mb.in_mode     = 1'b0;
        mb.in_tag      = '0;
        mb.out_ready   = 1'b1;
        sbus.in_valid  = 1'b0;
        sbus.in_data   = '0;
        sbus.in_mode   = 1'b0;
        sbus.in_tag    = '0;
        sbus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(mb.out_valid), 64'd0);
        chk("rst_out_data", 64'(mb.out_data), 64'd0);
        chk("rst_out_tag", 64'(mb.out_tag), 64'd0);
        chk("rst_small_out_valid", 64'(sbus.out_valid), 64'd0);
        rst = 1'b0;

        // directed vectors, one at a time, latency checked
        chk_lat = 1'b1;
        for (int i = 0; i < 9; i++) begin
            main_cycle(1'b1, vecs[i].x, vecs[i].mode, 4'(i), vecs[i].exp, 1'b1);
            bubbles(5);
            chk("basic_vec_done", 64'(sq_main.size()), 64'd0);
        end

        // back-to-back random stream, full throughput
        track_idle = 1'b1;
        seen_out   = 1'b0;
        idle_cnt   = 0;
        for (int i = 0; i < 1000; i++) begin
            rnd = {$urandom, $urandom};
            x   = rnd[45:0];
            m   = 1'($urandom_range(0, 1));
            main_cycle(1'b1, x, m, 4'(i), ref_main(x, m), 1'b1);
        end
        bubbles(8);
        track_idle = 1'b0;
        chk("tp_idle_cycles", 64'(idle_cnt), 64'd0);
        chk("tp_drain", 64'(sq_main.size()), 64'd0);

        // random back-pressure while feeding continuously
        chk_lat = 1'b0;
        sent    = 0;
        rcvd    = 0;
        for (int i = 0; i < 600; i++) begin
            rnd = {$urandom, $urandom};
            x   = rnd[45:0];
            m   = 1'($urandom_range(0, 1));
            main_cycle(1'b1, x, m, 4'(i), ref_main(x, m), 1'($urandom_range(0, 1)));
        end
        bubbles(10);
        chk("bp_drain", 64'(sq_main.size()), 64'd0);
        chk("bp_count", 64'(rcvd), 64'(sent));

        // reset with three operands in flight
        chk_lat = 1'b1;
        main_cycle(1'b1, 46'd5, MODE_CANON, 4'd1, 24'd5, 1'b1);
        main_cycle(1'b1, 46'd6, MODE_CANON, 4'd2, 24'd6, 1'b1);
        main_cycle(1'b1, 46'd7, MODE_CANON, 4'd3, 24'd7, 1'b1);
        pulse_reset();
        main_cycle(1'b0, 46'd0, 1'b0, 4'd0, 24'd0, 1'b0);
        bubbles(8);
        r0 = rcvd;
        main_cycle(1'b1, 46'd8380418, MODE_CANON, 4'hA, 24'd1, 1'b1);
        bubbles(6);
        chk("rst_recover_drain", 64'(sq_main.size()), 64'd0);
        chk("rst_recover_count", 64'(rcvd - r0), 64'd1);

        // Q=3329 instance, strided sweep in both modes plus endpoints
        for (logic [31:0] xs = 32'd0; xs < 32'd16777216; xs = xs + 32'd2039) begin
            small_cycle(1'b1, xs[23:0], MODE_CANON);
            small_cycle(1'b1, xs[23:0], MODE_CENTER);
        end
        small_cycle(1'b1, 24'hFFFFFF, MODE_CANON);
        small_cycle(1'b1, 24'hFFFFFF, MODE_CENTER);
        for (int i = 0; i < 8; i++) small_cycle(1'b0, 24'd0, 1'b0);
        chk("small_drain", 64'(sq_small.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
